// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock with a registered carry between chunks.
// Optional signed-overflow output enabled by defining ADDER_OVERFLOW_EN.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
`ifdef ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] psum_shift;
`ifdef ADDER_OVERFLOW_EN
  // Operand sign bits are kept aside because xr/yr are shifted away during the add.
  logic             xs_q, xs_d, ys_q, ys_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef ADDER_OVERFLOW_EN
    xs_d    = xs_q;
    ys_d    = ys_q;
    ovf_d   = ovf_q;
`endif

    slice_sum  = {1'b0, xr_q[CHUNK-1:0]} + {1'b0, yr_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    // Each new chunk enters at the MSB end; after NCH shifts chunk 0 sits at the LSB.
    psum_shift = psum_q >> CHUNK;
    psum_shift[WIDTH-1 -: CHUNK] = slice_sum[CHUNK-1:0];

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          xr_d    = x;
          yr_d    = y;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
`ifdef ADDER_OVERFLOW_EN
          xs_d    = x[WIDTH-1];
          ys_d    = y[WIDTH-1];
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        xr_d    = xr_q >> CHUNK;
        yr_d    = yr_q >> CHUNK;
        carry_d = slice_sum[CHUNK];
        psum_d  = psum_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCH - 1)) begin
          s_d     = psum_shift;
          cout_d  = slice_sum[CHUNK];
`ifdef ADDER_OVERFLOW_EN
          ovf_d   = (xs_q == ys_q) && (psum_shift[WIDTH-1] != xs_q);
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef ADDER_OVERFLOW_EN
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
`ifdef ADDER_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: CHUNK=4 and CHUNK=16 instances share inputs, checked
// against plain-arithmetic expectations (table vectors, corner sequences, random ops).
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] x, y;
  logic        busy4, done4, cout4, busy16, done16, cout16;
  logic [15:0] s4, s16;
`ifdef ADDER_OVERFLOW_EN
  logic        ovf4, ovf16;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
    .busy(busy4), .done(done4), .s(s4),
`ifdef ADDER_OVERFLOW_EN
    .ovf(ovf4),
`endif
    .cout(cout4));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
    .busy(busy16), .done(done16), .s(s16),
`ifdef ADDER_OVERFLOW_EN
    .ovf(ovf16),
`endif
    .cout(cout16));

  typedef struct {
    logic [15:0] x, y;
    logic        cin;
    logic [15:0] exp_s;
    logic        exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: the whole sum in one 17-bit add; overflow from operand/result signs.
  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] r;
    r = ref_sum(a, b, c);
    return (a[15] == b[15]) && (r[15] != a[15]);
  endfunction

  // One full operation on both instances; scrambles inputs after the accept edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c);
    int          d4, d16, nbusy;
    logic [15:0] prev_s;
    logic        hold_ok;
    logic [16:0] r;
    r = ref_sum(a, b, c);
    prev_s = s4;
    hold_ok = 1'b1;
    d4 = -1; d16 = -1; nbusy = 0;
    x = a; y = b; cin = c; start = 1'b1;
    for (int e = 1; e <= 20 && d4 < 0; e++) begin
      tick();
      if (e == 1) begin
        start = 1'b0;
        x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom);
      end
      if (busy4) nbusy++;
      if (done16 && d16 < 0) begin
        d16 = e;
        chk({tag, " s16"}, {16'd0, s16}, {16'd0, r[15:0]});
        chk({tag, " cout16"}, {31'd0, cout16}, {31'd0, r[16]});
      end
      if (done4) d4 = e;
      else if (s4 !== prev_s) hold_ok = 1'b0;
    end
    if (d4 < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no done within 20 edges, expected at edge 5", tag);
    end else begin
      chk({tag, " s4"}, {16'd0, s4}, {16'd0, r[15:0]});
      chk({tag, " cout4"}, {31'd0, cout4}, {31'd0, r[16]});
`ifdef ADDER_OVERFLOW_EN
      chk({tag, " ovf4"}, {31'd0, ovf4}, {31'd0, ref_ovf(a, b, c)});
`endif
    end
    chk({tag, " lat4"}, d4, 5);
    chk({tag, " lat16"}, d16, 2);
    chk({tag, " busy_cycles"}, nbusy, 4);
    chk({tag, " s_hold"}, {31'd0, hold_ok}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [16:0] r;
    int          seen;
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0});

    // Reset with start and all-ones operands held: nothing may start.
    rst = 1'b1; start = 1'b1; x = 16'hFFFF; y = 16'hFFFF; cin = 1'b1;
    tick(); tick();
    chk("rst busy", {31'd0, busy4}, 32'd0);
    chk("rst done", {31'd0, done4}, 32'd0);
    chk("rst s", {16'd0, s4}, 32'd0);
    chk("rst cout", {31'd0, cout4}, 32'd0);
    chk("rst busy16", {31'd0, busy16}, 32'd0);
`ifdef ADDER_OVERFLOW_EN
    chk("rst ovf", {31'd0, ovf4}, 32'd0);
`endif
    rst = 1'b0; start = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].cin);
      chk($sformatf("vec%0d tbl_s", i), {16'd0, s4}, {16'd0, vecs[i].exp_s});
      chk($sformatf("vec%0d tbl_cout", i), {31'd0, cout4}, {31'd0, vecs[i].exp_cout});
      tick();
    end

    // start during BUSY is ignored; start in the DONE cycle chains a second run.
    x = 16'h0001; y = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();
    x = 16'hAAAA;
    seen = 0;
    for (int e = 2; e <= 20 && seen == 0; e++) begin
      tick();
      if (done4) seen = e;
    end
    chk("b2b first lat", seen, 5);
    chk("b2b first s", {16'd0, s4}, 32'h0002);
    x = 16'h0003; y = 16'h0004; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b restart busy", {31'd0, busy4}, 32'd1);
    seen = 0;
    for (int e = 2; e <= 20 && seen == 0; e++) begin
      tick();
      if (done4) seen = e;
    end
    chk("b2b second lat", seen, 5);
    chk("b2b second s", {16'd0, s4}, 32'h0007);
    tick();

    // Reset in the second BUSY cycle aborts the run with no done pulse.
    x = 16'h1111; y = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", {31'd0, busy4}, 32'd0);
    chk("abort s", {16'd0, s4}, 32'd0);
    chk("abort cout", {31'd0, cout4}, 32'd0);
    seen = 0;
    for (int e = 0; e < 8; e++) begin
      if (done4) seen++;
      tick();
    end
    chk("abort no_done", seen, 0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      logic c;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      if (i % 8 == 0) a = 16'hFFFF - b;
      run_op($sformatf("rnd%0d", i), a, b, c);
      if (($urandom & 1) == 1) tick();
    end

    r = ref_sum(16'h7FFF, 16'h0001, 1'b0);
    run_op("ovf_case", 16'h7FFF, 16'h0001, 1'b0);
    chk("ovf_case s", {16'd0, s4}, {16'd0, r[15:0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
